// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1/8N2 UART transmitter.
// Bytes queue in a small FIFO and leave LSB-first after a start bit.
module uart_tx #(
  parameter int clocks_per_bit = 4,
  parameter int stop_bits      = 1,
  parameter int fifo_depth     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        out_ready,
  output logic                        out_serial,
  output logic                        out_idle,
  output logic [$clog2(fifo_depth):0] out_count
);
  localparam int AW = $clog2(fifo_depth);
  localparam int CW =
    (clocks_per_bit > 2) ? $clog2(clocks_per_bit) : 1;
  localparam logic [CW-1:0] RELOAD =
    CW'(clocks_per_bit - 1);
  localparam logic [AW:0] FULL = (AW+1)'(fifo_depth);
  localparam logic LAST_STOP = (stop_bits == 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          stop_cnt, stop_cnt_n;
  logic          serial_n;
  logic          idle_n;
  logic [AW:0]   count_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [fifo_depth];
  logic          push, pop, has_data;

  assign out_ready = (out_count != FULL);
  assign push      = in_valid && out_ready;
  assign has_data  = (out_count != '0);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shift_n    = shift;
    stop_cnt_n = stop_cnt;
    serial_n   = out_serial;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        serial_n = 1'b1;
        if (has_data) begin
          pop      = 1'b1;
          shift_n  = mem[rd_ptr];
          serial_n = 1'b0;
          cnt_n    = RELOAD;
          state_n  = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          serial_n = shift[0];
          shift_n  = shift >> 1;
          idx_n    = 3'd7;
          cnt_n    = RELOAD;
          state_n  = DATA;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (idx == 3'd0) begin
          serial_n   = 1'b1;
          stop_cnt_n = 1'b0;
          cnt_n      = RELOAD;
          state_n    = STOP;
        end else begin
          serial_n = shift[0];
          shift_n  = shift >> 1;
          idx_n    = idx - 3'd1;
          cnt_n    = RELOAD;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (stop_cnt != LAST_STOP) begin
          stop_cnt_n = 1'b1;
          cnt_n      = RELOAD;
        end else if (has_data) begin
          // chain straight into the next start bit
          pop      = 1'b1;
          shift_n  = mem[rd_ptr];
          serial_n = 1'b0;
          cnt_n    = RELOAD;
          state_n  = START;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    count_n = out_count + (AW+1)'(push)
            - (AW+1)'(pop);
    idle_n  = (state_n == IDLE) && (count_n == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      stop_cnt   <= 1'b0;
      out_serial <= 1'b1;
      out_idle   <= 1'b1;
      out_count  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      stop_cnt   <= stop_cnt_n;
      out_serial <= serial_n;
      out_idle   <= idle_n;
      out_count  <= count_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always @(posedge clk) begin
    assert ((stop_bits == 1 || stop_bits == 2)
            && clocks_per_bit >= 2)
      else $error("uart_tx: bad stop_bits/clocks_per_bit");
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx with a frame-level reference model
// and a serial monitor on the 1-stop-bit instance.
module tb_uart_tx;
  localparam int C = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0][7:0] din;
  logic [1:0]      vld;
  logic [1:0]      rdy;
  logic [1:0]      ser;
  logic [1:0]      idl;
  logic [1:0][2:0] cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.clocks_per_bit(C), .stop_bits(1),
            .fifo_depth(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data(din[0]), .in_valid(vld[0]),
    .out_ready(rdy[0]), .out_serial(ser[0]),
    .out_idle(idl[0]), .out_count(cnt[0]));

  uart_tx #(.clocks_per_bit(C), .stop_bits(2),
            .fifo_depth(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(din[1]), .in_valid(vld[1]),
    .out_ready(rdy[1]), .out_serial(ser[1]),
    .out_idle(idl[1]), .out_count(cnt[1]));

  // Reference model: queue of waiting bytes plus the start time
  // and value of the latest frame; line derived by arithmetic.
  logic [7:0] mbuf [2][DEPTH];
  int         mhead [2];
  int         mn [2];
  int         fs [2];
  logic [7:0] fb [2];
  int         t;
  logic [5:0] e_pk [2];
  logic [7:0] acc0 [$];

  function automatic int flen(int d);
    return (d == 0 ? 10 : 11) * C;
  endfunction

  function automatic logic line_at(int d);
    int dt = t - fs[d];
    int k;
    if (dt >= flen(d)) return 1'b1;
    k = dt / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return fb[d][k-1];
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mn[d] = 0;
      mhead[d] = 0;
      fs[d] = -100000;
      fb[d] = 8'h00;
    end
  endtask

  task automatic model_outputs();
    for (int d = 0; d < 2; d++)
      e_pk[d] = {line_at(d), mn[d] != DEPTH,
                 mn[d] == 0 && (t - fs[d]) >= flen(d),
                 3'(mn[d])};
  endtask

  initial begin
    int n;
    t = 0;
    model_clear();
    model_outputs();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
      end else begin
        t++;
        for (int d = 0; d < 2; d++) begin
          n = mn[d];
          if (n != 0 && t >= fs[d] + flen(d)) begin
            fb[d] = mbuf[d][mhead[d]];
            mhead[d] = (mhead[d] + 1) % DEPTH;
            mn[d]--;
            fs[d] = t;
          end
          if (vld[d] && n != DEPTH) begin
            mbuf[d][(mhead[d] + mn[d]) % DEPTH] = din[d];
            mn[d]++;
            if (d == 0) acc0.push_back(din[d]);
          end
        end
      end
      model_outputs();
    end
  end

  // Serial monitor on dut0: samples mid-bit at negedges.
  logic [7:0] rxq [$];
  int         rst_ep = 0;

  initial forever begin
    @(negedge rst_n);
    rst_ep++;
  end

  initial begin
    int ep;
    logic ok;
    logic [7:0] b;
    forever begin
      @(negedge ser[0]);
      ep = rst_ep;
      b = 8'h00;
      repeat (3) @(negedge clk);
      ok = (ser[0] === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        b[i] = ser[0];
      end
      repeat (C) @(negedge clk);
      if (ser[0] !== 1'b1) ok = 1'b0;
      if (ok && ep == rst_ep) rxq.push_back(b);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    vld = '0;
    din = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ser[d], rdy[d], idl[d], cnt[d]} !== 6'b111000) begin
        errors++;
        $display("FAIL reset dut%0d got %b want 111000",
                 d, {ser[d], rdy[d], idl[d], cnt[d]});
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [9:0] pat;
    logic want;
    pat = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k <= 46; k++) begin
      @(negedge clk);
      checks++;
      if ({ser[0], rdy[0], idl[0], cnt[0]} !== e_pk[0]) begin
        errors++;
        $display("FAIL single_model k=%0d got %b want %b",
                 k, {ser[0], rdy[0], idl[0], cnt[0]}, e_pk[0]);
      end
      if (k == 1) begin
        checks++;
        if ({cnt[0], idl[0], ser[0]} !== {3'd1, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL single_e0 cnt/idle/ser got %b want 00101",
                   {cnt[0], idl[0], ser[0]});
        end
      end
      if (k >= 2 && k <= 42) begin
        want = (k <= 41) ? pat[(k - 2) / C] : 1'b1;
        checks++;
        if (ser[0] !== want || idl[0] !== (k == 42)) begin
          errors++;
          $display("FAIL single_bits k=%0d ser=%b/%b idle=%b/%b",
                   k, ser[0], want, idl[0], k == 42);
        end
      end
      vld[0] = (k == 0);
      din[0] = 8'hA5;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int peak;
    bytes = '{8'h00, 8'hFF, 8'h3C};
    peak = 0;
    rxq.delete();
    for (int k = 0; k <= 130; k++) begin
      @(negedge clk);
      checks++;
      if ({ser[0], rdy[0], idl[0], cnt[0]} !== e_pk[0]) begin
        errors++;
        $display("FAIL b2b_model k=%0d got %b want %b",
                 k, {ser[0], rdy[0], idl[0], cnt[0]}, e_pk[0]);
      end
      if (int'(cnt[0]) > peak) peak = int'(cnt[0]);
      if (k == 41 || k == 42 || k == 82) begin
        checks++;
        if (ser[0] !== (k == 41)) begin
          errors++;
          $display("FAIL b2b_seam k=%0d ser=%b want %b",
                   k, ser[0], k == 41);
        end
      end
      if (k == 121 || k == 122) begin
        checks++;
        if (idl[0] !== (k == 122)) begin
          errors++;
          $display("FAIL b2b_idle k=%0d idle=%b want %b",
                   k, idl[0], k == 122);
        end
      end
      vld[0] = (k < 3);
      din[0] = (k < 3) ? bytes[k] : 8'h00;
    end
    checks++;
    if (peak != 2) begin
      errors++;
      $display("FAIL b2b_peak count=%0d want 2", peak);
    end
    checks++;
    if (rxq.size() != 3 || rxq[0] !== 8'h00
        || rxq[1] !== 8'hFF || rxq[2] !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_rx got %p want 00,ff,3c", rxq);
    end
  endtask

  task automatic test_full_fifo();
    logic [7:0] b [6];
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    rxq.delete();
    for (int k = 0; k <= 260; k++) begin
      @(negedge clk);
      checks++;
      if ({ser[0], rdy[0], idl[0], cnt[0]} !== e_pk[0]) begin
        errors++;
        $display("FAIL full_model k=%0d got %b want %b",
                 k, {ser[0], rdy[0], idl[0], cnt[0]}, e_pk[0]);
      end
      if (k == 7 || k == 41 || k == 42 || k == 43) begin
        checks++;
        if ({rdy[0], cnt[0]} !== ((k == 42) ? 4'b1011 : 4'b0100))
        begin
          errors++;
          $display("FAIL full_ready k=%0d rdy/cnt got %b want %b",
                   k, {rdy[0], cnt[0]},
                   (k == 42) ? 4'b1011 : 4'b0100);
        end
      end
      vld[0] = (k == 0) || (k >= 3 && k <= 42);
      din[0] = (k == 0) ? b[0] : (k <= 6 ? b[k-2] : b[5]);
    end
    checks++;
    if (idl[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_drain idle=%b want 1", idl[0]);
    end
    checks++;
    if (rxq.size() != 6) begin
      errors++;
      $display("FAIL full_rx_count got %0d want 6", rxq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rxq[i] !== b[i]) begin
          errors++;
          $display("FAIL full_rx[%0d] got %h want %h",
                   i, rxq[i], b[i]);
        end
      end
    end
  endtask

  task automatic test_two_stop();
    logic want;
    for (int k = 0; k <= 95; k++) begin
      @(negedge clk);
      checks++;
      if ({ser[1], rdy[1], idl[1], cnt[1]} !== e_pk[1]) begin
        errors++;
        $display("FAIL stop2_model k=%0d got %b want %b",
                 k, {ser[1], rdy[1], idl[1], cnt[1]}, e_pk[1]);
      end
      if ((k >= 38 && k <= 46) || (k >= 81 && k <= 89)) begin
        want = !(k == 46 || k == 81);
        checks++;
        if (ser[1] !== want) begin
          errors++;
          $display("FAIL stop2_line k=%0d ser=%b want %b",
                   k, ser[1], want);
        end
      end
      if (k == 89 || k == 90) begin
        checks++;
        if (idl[1] !== (k == 90)) begin
          errors++;
          $display("FAIL stop2_idle k=%0d idle=%b want %b",
                   k, idl[1], k == 90);
        end
      end
      vld[1] = (k < 2);
      din[1] = (k == 0) ? 8'h81 : 8'h01;
    end
    vld[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 19; k++) begin
      @(negedge clk);
      checks++;
      if ({ser[0], rdy[0], idl[0], cnt[0]} !== e_pk[0]) begin
        errors++;
        $display("FAIL rstmid_model k=%0d got %b want %b",
                 k, {ser[0], rdy[0], idl[0], cnt[0]}, e_pk[0]);
      end
      vld[0] = (k < 3);
      din[0] = (k == 0) ? 8'h55 : 8'($urandom);
    end
    checks++;
    if ({ser[0], cnt[0]} !== {1'b0, 3'd2}) begin
      errors++;
      $display("FAIL rstmid_pre ser/cnt got %b want 0010",
               {ser[0], cnt[0]});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ser[0], rdy[0], idl[0], cnt[0]} !== 6'b111000) begin
      errors++;
      $display("FAIL rstmid_now got %b want 111000",
               {ser[0], rdy[0], idl[0], cnt[0]});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      checks++;
      if ({ser[0], rdy[0], idl[0], cnt[0]} !== 6'b111000) begin
        errors++;
        $display("FAIL rstmid_after k=%0d got %b want 111000",
                 k, {ser[0], rdy[0], idl[0], cnt[0]});
      end
    end
  endtask

  task automatic test_random();
    rxq.delete();
    acc0.delete();
    for (int k = 0; k < 1900; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({ser[d], rdy[d], idl[d], cnt[d]} !== e_pk[d]) begin
          errors++;
          $display("FAIL rand_model dut%0d k=%0d got %b want %b",
                   d, k, {ser[d], rdy[d], idl[d], cnt[d]}, e_pk[d]);
        end
        vld[d] = (k < 1600) &&
                 ($urandom_range(0, (k < 800) ? 3 : 60) == 0);
        din[d] = 8'($urandom);
      end
    end
    checks++;
    if (idl !== 2'b11) begin
      errors++;
      $display("FAIL rand_drain idle=%b want 11", idl);
    end
    checks++;
    if (rxq.size() != acc0.size()) begin
      errors++;
      $display("FAIL rand_rx_count got %0d want %0d",
               rxq.size(), acc0.size());
    end else begin
      for (int i = 0; i < rxq.size(); i++) begin
        checks++;
        if (rxq[i] !== acc0[i]) begin
          errors++;
          $display("FAIL rand_rx[%0d] got %h want %h",
                   i, rxq[i], acc0[i]);
        end
      end
    end
  endtask

  task automatic test_loopback();
    int w;
    rxq.delete();
    acc0.delete();
    for (int i = 0; i < 256; i++) begin
      vld[0] = 1'b1;
      din[0] = 8'(i);
      w = 0;
      while (acc0.size() != i + 1 && w < 100) begin
        @(negedge clk);
        w++;
        checks++;
        if ({ser[0], rdy[0], idl[0], cnt[0]} !== e_pk[0]) begin
          errors++;
          $display("FAIL loop_model i=%0d got %b want %b",
                   i, {ser[0], rdy[0], idl[0], cnt[0]}, e_pk[0]);
        end
      end
      if (acc0.size() != i + 1) begin
        errors++;
        $display("FAIL loop_accept byte %0d not taken in %0d cycles",
                 i, w);
        break;
      end
    end
    vld[0] = 1'b0;
    for (int k = 0; k < 300 && idl[0] !== 1'b1; k++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (idl[0] !== 1'b1) begin
      errors++;
      $display("FAIL loop_drain idle=%b want 1", idl[0]);
    end
    checks++;
    if (rxq.size() != 256) begin
      errors++;
      $display("FAIL loop_rx_count got %0d want 256", rxq.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (rxq[i] !== 8'(i)) begin
          errors++;
          $display("FAIL loop_rx[%0d] got %h want %h",
                   i, rxq[i], 8'(i));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vld = '0;
    din = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_two_stop();
    test_reset_mid();
    test_random();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1/8N2 UART transmitter. Accepts bytes over a valid/ready handshake into a small FIFO and serializes each byte onto a single line: start bit, 8 data bits LSB-first, then 1 or 2 stop bits, each held for `clocks_per_bit` clocks. It is the transmit-side counterpart to the UART receiver on the same link, and shares its bit timing: one bit every `clocks_per_bit` clocks, idle-high line.

## Interface
- `clocks_per_bit`, 4: clocks per serial bit; legal range is 2 or more.
- `stop_bits`, 1: stop bits per frame; legal values are 1 or 2.
- `fifo_depth`, 4: FIFO entries; power of two, 2 or more.
- `clk`  input  1  the single clock; everything is on the posedge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_data`  input  8  byte to send.
- `in_valid`  input  1  `in_data` is offered this cycle.
- `out_ready`  output  1  the FIFO can accept a byte this cycle.
- `out_serial`  output  1  the serial line, registered, idle high.
- `out_idle`  output  1  the FIFO is empty and no frame is in flight.
- `out_count`  output  $clog2(fifo_depth)+1  number of bytes held in the FIFO, excluding the byte in the shifter.

## Operation
- **Push:** a byte is accepted on a posedge when `in_valid && out_ready`.
  - `out_ready = (out_count != fifo_depth)`, decoded directly from registers with no combinational path from `in_valid`.
  - When `out_ready` is low, `in_valid` is ignored and the sender holds its data.
- **Pop:** the shifter pops the FIFO head only when the FIFO is non-empty at the start of that cycle, i.e. from the registered count.
  - Push and pop in the same cycle: both occur and `out_count` is unchanged.
  - A push into an empty FIFO does not bypass to the shifter in the same cycle.
- **FIFO storage:** read/write pointers of $clog2(fifo_depth) bits, wrapping naturally. `out_count` is tracked separately, which gives unambiguous full/empty.
- **State machine** (states IDLE, START, DATA, STOP):
  - IDLE: line high. If the FIFO is non-empty, pop into an 8-bit shift register, drive the line low, load the cycle counter with `clocks_per_bit-1`, and go to START.
  - START: when the counter reaches 0, drive `shift[0]`, shift right, set the bit index to 7, reload the counter, and go to DATA.
  - DATA: at each counter expiry, drive the next bit and decrement the index. After bit 7 has been held, drive the line high, reload the counter, and go to STOP.
  - STOP: hold the line high for `stop_bits*clocks_per_bit` clocks, counting via a stop-bit counter.
    - At the final expiry, if the FIFO is non-empty: pop, drive low, and go to START with no idle gap.
    - Otherwise go to IDLE.
- **Widths and encodings:**
  - Cycle counter: $clog2(clocks_per_bit) bits, decrementing. It uses the same down-count-to-zero timing as the receiver.
  - Bit index: 3 bits.
- `out_idle` = (state == IDLE) && (`out_count` == 0), registered.
- **Reset (any time, including mid-frame):** all of the following take effect immediately, and the partial frame is abandoned, not completed.
  - `out_serial=1`, state IDLE, FIFO flushed (pointers and count 0).
  - `out_ready=1`, `out_idle=1`, `out_count=0`.
- **Invalid parameters:** `stop_bits` outside {1,2} or `clocks_per_bit` < 2 is a configuration error, checked by a simulation-time assertion.

## Timing
- Let E0 be the accepting edge for a byte pushed into an empty FIFO while the block is in IDLE.
  - E0: `out_count` becomes 1 and `out_idle` goes 0.
  - E1 = E0+1: pop; `out_count` returns to 0 and `out_serial` falls.
- Start bit occupies clocks [E1, E1+C), with C = `clocks_per_bit`.
- Data bit i (0..7) occupies [E1+(1+i)C, E1+(2+i)C).
- Stop bits occupy [E1+9C, E1+(9+stop_bits)C).
- Frame length F = (9+stop_bits)·C clocks.
- **Back-to-back frames:** the next start bit begins exactly at E1+F.
- **Last frame:** if the FIFO is empty at E1+F, the line stays high and `out_idle` rises on the edge at E1+F.
- **Throughput:** sustained at one byte per F clocks. The FIFO absorbs bursts of up to `fifo_depth` bytes, plus 1 byte in the shifter.

## Test plan
- **Single byte:** C=4, stop_bits=1, push 0xA5 at E0.
  - `out_serial` falls at E0+1.
  - Line reads 0,1,0,1,0,0,1,0,1 (start, then LSB-first data), then 1, each bit held exactly 4 clocks.
  - `out_idle` rises at E0+41.
- **Back-to-back:** push 0x00, 0xFF, 0x3C on consecutive cycles.
  - Three contiguous 40-clock frames with no high gap between the stop bit and the next start bit.
  - `out_count` peaks at 2.
- **Full FIFO:** with the transmitter busy, push 4 bytes.
  - `out_ready` drops after the 4th push.
  - A 5th byte held with `in_valid=1` is accepted only on the edge after the next pop.
  - No byte is lost or duplicated.
- **Two stop bits:** stop_bits=2, push 0x81 then 0x01. The line is high for 8 clocks between the frames, and each frame is 44 clocks long.
- **Reset mid-frame:** assert `rst_n` low during data bit 3 of 0x55 with 2 bytes queued.
  - `out_serial=1`, `out_count=0`, `out_ready=1` immediately.
  - After release, the line stays idle with no residual frame.
- **Loopback:** connect `out_serial` to the receiver block with the same C and push 0x00..0xFF. The receiver reports each value exactly once, in order.
